// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter among NREQ byte requesters. Arbitration is
//   round-robin with a message lock: the granted requester keeps the grant
//   until it hands over a byte flagged last, so strings never interleave.
//   Each byte is walked through the transmitter's valid/busy handshake.
//
// Handshakes:
//   Requester side: a byte moves when req_valid[i] and req_ready[i] are both
//   high in the same cycle. The requester holds valid/data/last stable until
//   then. Once ready is seen, the byte belongs to the arbiter.
//   UART side: tx_valid pulses for one cycle per byte. tx_busy is then
//   expected to rise and later fall, which marks the end of the frame.
//
// Ports:
//   clk, resetn   clock, synchronous active-low reset
//   req_valid     per-requester byte available
//   req_data      byte lanes, lane i = req_data[8i+7:8i]
//   req_last      per-requester end-of-message flag
//   req_ready     one-hot combinational consume strobe
//   tx_data       registered byte to the UART
//   tx_valid      registered one-cycle launch pulse to the UART
//   tx_busy       UART frame in progress
//   grant_id      id of the last granted requester
//   locked        message in progress, only grant_id is served
//   err_timeout   one-cycle pulse on busy-wait or lock-wait expiry
//   dbgState      current FSM state (IDLE=0, LAUNCH=1, WAITBUSY=2, WAITDONE=3)

module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int BUSY_WAIT = 16,
  parameter int LOCK_WAIT = 4096
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_busy,
  output logic [IDW-1:0]    grant_id,
  output logic              locked,
  output logic              err_timeout,
  output logic [1:0]        dbgState
);

  localparam int BCW = $clog2(BUSY_WAIT + 1);
  localparam int LCW = $clog2(LOCK_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH   = 2'd1,
    WAITBUSY = 2'd2,
    WAITDONE = 2'd3
  } state_t;

  state_t         state;
  logic [IDW-1:0] rrPtr;
  logic [BCW-1:0] busyCnt;
  logic [LCW-1:0] lockCnt;

  logic           candFound;
  logic [IDW-1:0] candSel;
  logic           grantNow;
  logic           lockIdle;

  // Candidate selection. While locked only the lock owner may be served.
  // Otherwise scan ptr+1 .. ptr+NREQ; the loop runs from the far end so
  // the nearest valid requester is the last one written and wins.
  always_comb begin
    candFound = 1'b0;
    candSel   = '0;
    if (locked) begin
      candFound = req_valid[grant_id];
      candSel   = grant_id;
    end else begin
      for (int k = NREQ; k >= 1; k--) begin
        if (req_valid[IDW'((int'(rrPtr) + k) % NREQ)]) begin
          candFound = 1'b1;
          candSel   = IDW'((int'(rrPtr) + k) % NREQ);
        end
      end
    end
  end

  assign grantNow  = resetn && (state == IDLE) && !tx_busy && candFound;
  assign req_ready = grantNow ? (NREQ'(1) << candSel) : '0;

  // Lock owner has nothing to send while we sit in IDLE: the lock timer runs.
  assign lockIdle  = (state == IDLE) && locked && !req_valid[grant_id];

  assign dbgState  = state;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      grant_id    <= '0;
      locked      <= 1'b0;
      err_timeout <= 1'b0;
      busyCnt     <= '0;
      lockCnt     <= '0;
      rrPtr       <= IDW'(NREQ - 1);
    end else begin
      tx_valid    <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (grantNow) begin
            tx_data  <= req_data[{candSel, 3'b000} +: 8];
            grant_id <= candSel;
            locked   <= ~req_last[candSel];
            rrPtr    <= candSel;
            lockCnt  <= '0;
            tx_valid <= 1'b1;
            state    <= LAUNCH;
          end else if (lockIdle) begin
            if (lockCnt == LCW'(LOCK_WAIT - 1)) begin
              err_timeout <= 1'b1;
              locked      <= 1'b0;
              lockCnt     <= '0;
            end else begin
              lockCnt <= lockCnt + 1'b1;
            end
          end
        end
        LAUNCH: begin
          // The launch cycle itself counts as the first cycle of the busy wait,
          // so err_timeout appears exactly BUSY_WAIT cycles after tx_valid.
          busyCnt <= BCW'(1);
          state   <= WAITBUSY;
        end
        WAITBUSY: begin
          if (tx_busy) begin
            state <= WAITDONE;
          end else if (busyCnt == BCW'(BUSY_WAIT - 1)) begin
            // Give up on the UART; the byte is treated as sent, lock kept.
            err_timeout <= 1'b1;
            busyCnt     <= '0;
            state       <= IDLE;
          end else begin
            busyCnt <= busyCnt + 1'b1;
          end
        end
        WAITDONE: begin
          if (!tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
